// File: rtl/adrv9001_mspi_ctrl.sv
// ============================================================================
// Module   : adrv9001_mspi_ctrl
// Purpose  : Two-port round-robin command arbiter and 3-byte transaction
//            sequencer in front of the ADRV9001 byte-stream SPI master.
// Option   : ADRV9001_MSPI_CTRL_TIMEOUT_EN adds a spi_done watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adrv9001_mspi_ctrl
`ifdef ADRV9001_MSPI_CTRL_TIMEOUT_EN
  #(
    parameter int TIMEOUT_CYCLES = 4096
  )
`endif
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        s0_cmd_valid,
  output logic        s0_cmd_ready,
  input  logic        s0_cmd_wr,
  input  logic [14:0] s0_cmd_addr,
  input  logic [7:0]  s0_cmd_wdata,
  output logic        s0_rsp_valid,
  output logic [7:0]  s0_rsp_rdata,
  output logic        s0_rsp_err,
  input  logic        s1_cmd_valid,
  output logic        s1_cmd_ready,
  input  logic        s1_cmd_wr,
  input  logic [14:0] s1_cmd_addr,
  input  logic [7:0]  s1_cmd_wdata,
  output logic        s1_rsp_valid,
  output logic [7:0]  s1_rsp_rdata,
  output logic        s1_rsp_err,
  output logic [7:0]  m_spi_tdata,
  output logic        m_spi_tvalid,
  input  logic        m_spi_tready,
  output logic        spi_enable,
  input  logic        spi_done,
  input  logic [7:0]  s_spi_tdata,
  input  logic        s_spi_tvalid,
  output logic        s_spi_tready
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_ptr;
  logic        r_gnt;
  logic        r_wr;
  logic [14:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic [1:0]  r_bcnt;
  logic        r_s_tready;
  logic        w_any;
  logic        w_gnt;
  logic        w_miso_fire;
  logic [7:0]  w_byte;
  logic        w_tmo;
  logic        w_err;

  assign w_any       = s0_cmd_valid | s1_cmd_valid;
  assign w_gnt       = (s0_cmd_valid & s1_cmd_valid) ? r_ptr : s1_cmd_valid;
  assign w_miso_fire = r_s_tready & s_spi_tvalid;

  always_comb begin
    w_byte = 8'h00;
    case (r_bcnt)
      2'd0:    w_byte = {~r_wr, r_addr[14:8]};
      2'd1:    w_byte = r_addr[7:0];
      default: w_byte = r_wr ? r_wdata : 8'h00;
    endcase
  end

`ifdef ADRV9001_MSPI_CTRL_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] r_tcnt;
  logic           r_err;

  // Counter reads 1 on the first RUN cycle, so it equals TIMEOUT_CYCLES on the last allowed one.
  assign w_tmo = (r_tcnt == TCW'(TIMEOUT_CYCLES));
  assign w_err = r_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state != ST_RUN) r_tcnt <= TCW'(1);
      else                   r_tcnt <= r_tcnt + TCW'(1);
      if (r_state == ST_ARB)
        r_err <= 1'b0;
      else if (r_state == ST_RUN && !spi_done && w_tmo)
        r_err <= 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
  assign w_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    s0_cmd_ready = 1'b0;
    s1_cmd_ready = 1'b0;
    m_spi_tvalid = 1'b0;
    m_spi_tdata  = 8'h00;
    spi_enable   = 1'b0;
    s0_rsp_valid = 1'b0;
    s1_rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_next = ST_ARB;
      end
      ST_ARB: begin
        s0_cmd_ready = w_any & ~w_gnt;
        s1_cmd_ready = w_any &  w_gnt;
        w_next       = w_any ? ST_LOAD : ST_IDLE;
      end
      ST_LOAD: begin
        m_spi_tvalid = 1'b1;
        m_spi_tdata  = w_byte;
        if (m_spi_tready && r_bcnt == 2'd2) w_next = ST_RUN;
      end
      ST_RUN: begin
        spi_enable = 1'b1;
        if (spi_done)   w_next = ST_DRAIN;
        else if (w_tmo) w_next = ST_RESP;
      end
      ST_DRAIN: begin
        if (w_miso_fire && r_bcnt == 2'd2) w_next = ST_RESP;
      end
      ST_RESP: begin
        s0_rsp_valid = ~r_gnt;
        s1_rsp_valid =  r_gnt;
        w_next       = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign s0_rsp_rdata = s0_rsp_valid ? r_rdata : 8'h00;
  assign s1_rsp_rdata = s1_rsp_valid ? r_rdata : 8'h00;
  assign s0_rsp_err   = s0_rsp_valid & w_err;
  assign s1_rsp_err   = s1_rsp_valid & w_err;
  assign s_spi_tready = r_s_tready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr      <= 1'b0;
      r_gnt      <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_bcnt     <= '0;
      r_s_tready <= 1'b0;
    end else begin
      // Registered so it stays low through reset and rises on the first IDLE cycle.
      r_s_tready <= (w_next == ST_IDLE) || (w_next == ST_DRAIN);
      case (r_state)
        ST_ARB: begin
          if (w_any) begin
            r_gnt   <= w_gnt;
            r_ptr   <= ~w_gnt;
            r_wr    <= w_gnt ? s1_cmd_wr    : s0_cmd_wr;
            r_addr  <= w_gnt ? s1_cmd_addr  : s0_cmd_addr;
            r_wdata <= w_gnt ? s1_cmd_wdata : s0_cmd_wdata;
          end
          r_rdata <= 8'h00;
          r_bcnt  <= 2'd0;
        end
        ST_LOAD: begin
          if (m_spi_tready)
            r_bcnt <= (r_bcnt == 2'd2) ? 2'd0 : r_bcnt + 2'd1;
        end
        ST_DRAIN: begin
          if (w_miso_fire) begin
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd2) r_rdata <= r_wr ? 8'h00 : s_spi_tdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adrv9001_mspi_ctrl.sv
// ============================================================================
// Module   : tb_adrv9001_mspi_ctrl
// Purpose  : Directed self-checking bench with a byte-stream SPI master model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adrv9001_mspi_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s0_cmd_valid, s0_cmd_ready, s0_cmd_wr;
  logic [14:0] s0_cmd_addr;
  logic [7:0]  s0_cmd_wdata;
  logic        s0_rsp_valid, s0_rsp_err;
  logic [7:0]  s0_rsp_rdata;
  logic        s1_cmd_valid, s1_cmd_ready, s1_cmd_wr;
  logic [14:0] s1_cmd_addr;
  logic [7:0]  s1_cmd_wdata;
  logic        s1_rsp_valid, s1_rsp_err;
  logic [7:0]  s1_rsp_rdata;
  logic [7:0]  m_spi_tdata;
  logic        m_spi_tvalid, m_spi_tready;
  logic        spi_enable;
  logic        spi_done     = 1'b0;
  logic [7:0]  s_spi_tdata  = 8'h00;
  logic        s_spi_tvalid = 1'b0;
  logic        s_spi_tready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef ADRV9001_MSPI_CTRL_TIMEOUT_EN
  adrv9001_mspi_ctrl #(.TIMEOUT_CYCLES(64)) dut (
`else
  adrv9001_mspi_ctrl dut (
`endif
    .clk(clk), .rstn(rstn),
    .s0_cmd_valid(s0_cmd_valid), .s0_cmd_ready(s0_cmd_ready), .s0_cmd_wr(s0_cmd_wr),
    .s0_cmd_addr(s0_cmd_addr), .s0_cmd_wdata(s0_cmd_wdata), .s0_rsp_valid(s0_rsp_valid),
    .s0_rsp_rdata(s0_rsp_rdata), .s0_rsp_err(s0_rsp_err),
    .s1_cmd_valid(s1_cmd_valid), .s1_cmd_ready(s1_cmd_ready), .s1_cmd_wr(s1_cmd_wr),
    .s1_cmd_addr(s1_cmd_addr), .s1_cmd_wdata(s1_cmd_wdata), .s1_rsp_valid(s1_rsp_valid),
    .s1_rsp_rdata(s1_rsp_rdata), .s1_rsp_err(s1_rsp_err),
    .m_spi_tdata(m_spi_tdata), .m_spi_tvalid(m_spi_tvalid), .m_spi_tready(m_spi_tready),
    .spi_enable(spi_enable), .spi_done(spi_done),
    .s_spi_tdata(s_spi_tdata), .s_spi_tvalid(s_spi_tvalid), .s_spi_tready(s_spi_tready)
  );

  // SPI master model and bus monitors
  logic [7:0] mosi_q[$];
  logic [7:0] miso_q[$];
  logic [7:0] mosi_hist[$];
  int         gnt_log[$];
  int         cyc = 0, rsp0 = 0, rsp1 = 0, overlap = 0, hold_bad = 0, xcnt = 0;
  int         en_rise = 0, en_fall = 0, bytes_at_en = 0;
  logic [7:0] last_rd0 = 8'h00, last_rd1 = 8'h00, hold_byte = 8'h00;
  logic       last_er0 = 1'b0, last_er1 = 1'b0;
  bit         mdone = 1'b0, en_prev = 1'b0, hold_pend = 1'b0, done_en = 1'b1;
  logic [7:0] ret_byte = 8'h00;

  always @(posedge clk) begin
    cyc++;
    if (m_spi_tvalid && m_spi_tready) begin
      mosi_q.push_back(m_spi_tdata);
      mosi_hist.push_back(m_spi_tdata);
    end
    if (hold_pend && !(m_spi_tvalid && m_spi_tdata == hold_byte)) hold_bad++;
    hold_pend = m_spi_tvalid && !m_spi_tready;
    hold_byte = m_spi_tdata;
    if (s_spi_tvalid && s_spi_tready && miso_q.size() != 0) void'(miso_q.pop_front());
    if (s0_cmd_valid && s0_cmd_ready) gnt_log.push_back(0);
    if (s1_cmd_valid && s1_cmd_ready) gnt_log.push_back(1);
    if (s0_cmd_ready && s1_cmd_ready) overlap++;
    if (s0_rsp_valid) begin rsp0++; last_rd0 = s0_rsp_rdata; last_er0 = s0_rsp_err; end
    if (s1_rsp_valid) begin rsp1++; last_rd1 = s1_rsp_rdata; last_er1 = s1_rsp_err; end
    if (spi_enable && !en_prev) begin en_rise = cyc; bytes_at_en = mosi_q.size(); end
    if (!spi_enable && en_prev) en_fall = cyc;
    en_prev = spi_enable;
    if (mdone && miso_q.size() == 0) begin
      mdone = 1'b0;
    end else if (spi_enable && done_en && !mdone && mosi_q.size() == 3) begin
      xcnt++;
      if (xcnt == 3) begin
        miso_q.push_back(mosi_q[0]);
        miso_q.push_back(mosi_q[1]);
        miso_q.push_back(ret_byte);
        mosi_q.delete();
        mdone = 1'b1;
        xcnt  = 0;
      end
    end
    spi_done     <= mdone;
    s_spi_tvalid <= (miso_q.size() != 0);
    s_spi_tdata  <= (miso_q.size() != 0) ? miso_q[0] : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input int p, input logic wr, input logic [14:0] a, input logic [7:0] d);
    bit seen = 1'b0;
    if (p == 0) begin
      s0_cmd_wr = wr; s0_cmd_addr = a; s0_cmd_wdata = d; s0_cmd_valid = 1'b1;
    end else begin
      s1_cmd_wr = wr; s1_cmd_addr = a; s1_cmd_wdata = d; s1_cmd_valid = 1'b1;
    end
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = (p == 0) ? s0_cmd_ready : s1_cmd_ready;
    end
    if (!seen) check("cmd_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    s0_cmd_valid = 1'b0;
    s1_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int p, output logic [7:0] rd, output logic er);
    int base = (p == 0) ? rsp0 : rsp1;
    bit got  = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      got = (((p == 0) ? rsp0 : rsp1) != base);
    end
    if (!got) check("rsp_timeout", 32'd0, 32'd1);
    rd = (p == 0) ? last_rd0 : last_rd1;
    er = (p == 0) ? last_er0 : last_er1;
  endtask

  initial begin
    logic [7:0] rd;
    logic       er;
    int         n0, n1, b0, b1;
    bit         d0, d1, flag;

    rstn = 1'b0;
    s0_cmd_valid = 1'b0; s0_cmd_wr = 1'b0; s0_cmd_addr = '0; s0_cmd_wdata = '0;
    s1_cmd_valid = 1'b0; s1_cmd_wr = 1'b0; s1_cmd_addr = '0; s1_cmd_wdata = '0;
    m_spi_tready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_flags", {s0_cmd_ready, s1_cmd_ready, s0_rsp_valid, s1_rsp_valid, s0_rsp_err,
                        s1_rsp_err, m_spi_tvalid, spi_enable, s_spi_tready}, 32'd0);
    check("rst_data", {s0_rsp_rdata, s1_rsp_rdata, m_spi_tdata}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_s_tready", s_spi_tready, 32'd1);

    // Port 0 write, loopback
    mosi_hist.delete(); ret_byte = 8'hA5;
    start_cmd(0, 1'b1, 15'h0123, 8'hA5);
    wait_rsp(0, rd, er);
    check("wr_b0", mosi_hist[0], 32'h01);
    check("wr_b1", mosi_hist[1], 32'h23);
    check("wr_b2", mosi_hist[2], 32'hA5);
    check("wr_rdata", rd, 32'h00);
    check("wr_err", er, 32'd0);

    // Port 1 read
    mosi_hist.delete(); ret_byte = 8'h5C;
    start_cmd(1, 1'b0, 15'h7F10, 8'h99);
    wait_rsp(1, rd, er);
    check("rd_b0", mosi_hist[0], 32'hFF);
    check("rd_b1", mosi_hist[1], 32'h10);
    check("rd_b2", mosi_hist[2], 32'h00);
    check("rd_rdata", rd, 32'h5C);
    check("rd_mosi_cnt", mosi_hist.size(), 32'd3);

    // Both ports continuously valid, two reads each
    gnt_log.delete(); ret_byte = 8'h11;
    s0_cmd_wr = 1'b0; s0_cmd_addr = 15'h0010; s1_cmd_wr = 1'b0; s1_cmd_addr = 15'h0020;
    s0_cmd_valid = 1'b1; s1_cmd_valid = 1'b1;
    n0 = 0; n1 = 0; d0 = 1'b0; d1 = 1'b0; b0 = rsp0; b1 = rsp1; flag = 1'b0;
    for (int c = 0; c < 600 && !flag; c++) begin
      @(negedge clk);
      if (d0) s0_cmd_valid = 1'b0;
      if (d1) s1_cmd_valid = 1'b0;
      if (s0_cmd_ready && s0_cmd_valid) begin n0++; if (n0 == 2) d0 = 1'b1; end
      if (s1_cmd_ready && s1_cmd_valid) begin n1++; if (n1 == 2) d1 = 1'b1; end
      flag = (rsp0 - b0 == 2) && (rsp1 - b1 == 2);
    end
    check("rr_done", flag, 32'd1);
    check("rr_cnt", gnt_log.size(), 32'd4);
    if (gnt_log.size() == 4) begin
      check("rr_g0", gnt_log[0], 32'd0);
      check("rr_g1", gnt_log[1], 32'd1);
      check("rr_g2", gnt_log[2], 32'd0);
      check("rr_g3", gnt_log[3], 32'd1);
    end
    check("rr_rsp0", rsp0 - b0, 32'd2);
    check("rr_rsp1", rsp1 - b1, 32'd2);
    check("rr_overlap", overlap, 32'd0);
    s0_cmd_valid = 1'b0; s1_cmd_valid = 1'b0;
    repeat (2) @(negedge clk);

    // m_spi_tready stall on byte1
    mosi_hist.delete(); ret_byte = 8'h00; hold_bad = 0;
    start_cmd(0, 1'b1, 15'h2A5B, 8'h3D);
    @(negedge clk);
    m_spi_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_b1", {m_spi_tvalid, m_spi_tdata}, {23'd0, 1'b1, 8'h5B});
    end
    check("stall_no_en", spi_enable, 32'd0);
    check("stall_hist", mosi_hist.size(), 32'd1);
    m_spi_tready = 1'b1;
    wait_rsp(0, rd, er);
    check("stall_sent", mosi_hist.size(), 32'd3);
    check("stall_b0", mosi_hist[0], 32'h2A);
    check("stall_b2", mosi_hist[2], 32'h3D);
    check("stall_en_bytes", bytes_at_en, 32'd3);
    check("stall_hold", hold_bad, 32'd0);

    // Reset during RUN with stale MISO bytes
    done_en = 1'b0;
    b1 = rsp1;
    start_cmd(1, 1'b0, 15'h0456, 8'h00);
    flag = 1'b0;
    for (int n = 0; n < 50 && !flag; n++) begin
      @(negedge clk);
      flag = spi_enable;
    end
    check("run_reached", flag, 32'd1);
    rstn = 1'b0;
    #1;
    check("mid_rst_flags", {s0_cmd_ready, s1_cmd_ready, s0_rsp_valid, s1_rsp_valid, s0_rsp_err,
                            s1_rsp_err, m_spi_tvalid, spi_enable, s_spi_tready}, 32'd0);
    check("mid_rst_data", {s0_rsp_rdata, s1_rsp_rdata, m_spi_tdata}, 32'd0);
    mosi_q.delete();
    miso_q.push_back(8'hE1);
    miso_q.push_back(8'hE2);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    check("stale_flushed", miso_q.size(), 32'd0);
    check("killed_no_rsp", rsp1 - b1, 32'd0);
    done_en = 1'b1; ret_byte = 8'h3C;
    start_cmd(0, 1'b0, 15'h0456, 8'h00);
    wait_rsp(0, rd, er);
    check("fresh_rdata", rd, 32'h3C);

`ifdef ADRV9001_MSPI_CTRL_TIMEOUT_EN
    // Watchdog: spi_done never arrives
    done_en = 1'b0;
    start_cmd(1, 1'b0, 15'h0777, 8'h00);
    wait_rsp(1, rd, er);
    check("tmo_err", er, 32'd1);
    check("tmo_rdata", rd, 32'h00);
    check("tmo_en_len", en_fall - en_rise, 32'd64);
    mosi_q.delete();
    done_en = 1'b1; ret_byte = 8'h77;
    repeat (3) @(negedge clk);
    start_cmd(0, 1'b0, 15'h0778, 8'h00);
    wait_rsp(0, rd, er);
    check("post_tmo_rdata", rd, 32'h77);
    check("post_tmo_err", er, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
